// File: rtl/riscv_fetch_pkg.sv
// Shared constants and types for the instruction fetch front end.
package riscv_fetch_pkg;

  localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;
  localparam logic [31:0] END_MARKER       = 32'h0000_0000;
  localparam logic [31:0] PC_STEP          = 32'h0000_0004;

  typedef enum logic [1:0] {
    BOOT = 2'd0,
    RUN  = 2'd1,
    HALT = 2'd2
  } fetch_state_t;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
  } fetch_entry_t;

  function automatic logic [31:0] align_pc(input logic [31:0] addr);
    return {addr[31:2], 2'b00};
  endfunction

endpackage

// File: rtl/fetch_queue.sv
// Small synchronous FIFO for fetched {pc, instr} entries; flush wins over push and pop.
module fetch_queue #(
  parameter int WIDTH = 64,
  parameter int DEPTH = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  input  logic             flush,
  output logic             full,
  output logic             empty,
  output logic [WIDTH-1:0] head
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] PTR_ONE = (AW + 1)'(1);

  logic [WIDTH-1:0] mem_r [DEPTH];
  logic [AW:0]      rd_ptr_r;
  logic [AW:0]      wr_ptr_r;
  logic             do_pop_s;
  logic             do_push_s;

  // Extra pointer bit distinguishes full from empty when the indices match.
  assign empty     = (rd_ptr_r == wr_ptr_r);
  assign full      = (rd_ptr_r[AW] != wr_ptr_r[AW]) && (rd_ptr_r[AW-1:0] == wr_ptr_r[AW-1:0]);
  assign head      = mem_r[rd_ptr_r[AW-1:0]];
  assign do_pop_s  = pop & ~empty & ~flush;
  assign do_push_s = push & (~full | do_pop_s) & ~flush;

  // Read/write pointer update
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_ptr_r <= '0;
      wr_ptr_r <= '0;
    end else if (flush) begin
      rd_ptr_r <= '0;
      wr_ptr_r <= '0;
    end else begin
      if (do_pop_s)  rd_ptr_r <= rd_ptr_r + PTR_ONE;
      if (do_push_s) wr_ptr_r <= wr_ptr_r + PTR_ONE;
    end
  end

  // Entry storage
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) mem_r[i] <= '0;
    end else if (do_push_s) begin
      mem_r[wr_ptr_r[AW-1:0]] <= push_data;
    end
  end

endmodule

// File: rtl/instr_fetch_unit.sv
// Fetch front end: owns the PC, reads instruction memory, queues {pc, instr}
// for decode, flushes on redirect and parks on an all-zero word.
module instr_fetch_unit
  import riscv_fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT,
  parameter int          QDEPTH   = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic [31:0] imem_addr,
  input  logic [31:0] imem_rdata,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_instr,
  output logic [31:0] out_pc,
  output logic        halted
);

  fetch_state_t state_r;
  logic [31:0]  pc_r;
  logic         halted_r;
  fetch_entry_t head_s;
  fetch_entry_t hold_r;
  fetch_entry_t shown_s;
  fetch_entry_t push_entry_s;
  logic         full_s;
  logic         empty_s;
  logic         pop_s;
  logic         push_s;
  logic         can_push_s;
  logic         is_end_s;

  assign pop_s        = ~empty_s & out_ready;
  assign can_push_s   = ~full_s | pop_s;
  assign is_end_s     = (imem_rdata == END_MARKER);
  assign push_entry_s = {pc_r, imem_rdata};

  // Push only while running with room, no redirect, and a real instruction word
  always_comb begin
    push_s = 1'b0;
    if (!redirect_valid && (state_r == RUN) && can_push_s && !is_end_s) begin
      push_s = 1'b1;
    end else begin
      push_s = 1'b0;
    end
  end

  fetch_queue #(
    .WIDTH ($bits(fetch_entry_t)),
    .DEPTH (QDEPTH)
  ) u_queue (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (push_s),
    .push_data (push_entry_s),
    .pop       (pop_s),
    .flush     (redirect_valid),
    .full      (full_s),
    .empty     (empty_s),
    .head      (head_s)
  );

  // Remember the last head shown so out_pc/out_instr hold while the queue is empty
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hold_r <= '0;
    end else if (!empty_s) begin
      hold_r <= head_s;
    end
  end

  // Head selection for the decode-facing outputs
  always_comb begin
    shown_s = hold_r;
    if (!empty_s) begin
      shown_s = head_s;
    end else begin
      shown_s = hold_r;
    end
  end

  assign out_valid = ~empty_s;
  assign out_pc    = shown_s.pc;
  assign out_instr = shown_s.instr;
  assign imem_addr = pc_r;
  assign halted    = halted_r;

  // Fetch FSM and program counter; a redirect overrides every state
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r  <= BOOT;
      pc_r     <= RESET_PC;
      halted_r <= 1'b0;
    end else if (redirect_valid) begin
      state_r  <= RUN;
      pc_r     <= align_pc(redirect_pc);
      halted_r <= 1'b0;
    end else begin
      case (state_r)
        BOOT: begin
          state_r  <= RUN;
          halted_r <= 1'b0;
        end
        RUN: begin
          if (can_push_s) begin
            if (is_end_s) begin
              state_r  <= HALT;
              halted_r <= 1'b1;
            end else begin
              pc_r <= pc_r + PC_STEP;
            end
          end
        end
        HALT: begin
          halted_r <= 1'b1;
        end
        default: begin
          state_r  <= BOOT;
          halted_r <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Self-checking bench for instr_fetch_unit: directed scenarios plus randomized
// traffic compared every cycle against a queue-based behavioural model.
module tb_instr_fetch_unit;

  localparam int          QDEPTH   = 2;
  localparam logic [31:0] RESET_PC = 32'h0000_0000;
  localparam int          P_BOOT   = 0;
  localparam int          P_RUN    = 1;
  localparam int          P_HALT   = 2;

  logic        clk;
  logic        rst_n;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic [31:0] imem_addr;
  logic [31:0] imem_rdata;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_instr;
  logic [31:0] out_pc;
  logic        halted;

  logic [31:0] mem [64];

  int n_cmp  = 0;
  int n_fail = 0;

  // behavioural model state
  logic [63:0] mq [$];
  logic [31:0] m_pc;
  int          m_phase;
  logic [63:0] m_shown;

  instr_fetch_unit #(
    .RESET_PC (RESET_PC),
    .QDEPTH   (QDEPTH)
  ) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .imem_addr      (imem_addr),
    .imem_rdata     (imem_rdata),
    .out_valid      (out_valid),
    .out_ready      (out_ready),
    .out_instr      (out_instr),
    .out_pc         (out_pc),
    .halted         (halted)
  );

  // memory has 64 words and aliases above 0xFC
  assign imem_rdata = mem[imem_addr[7:2]];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, got, exp, $time);
    end
  endtask

  function automatic void model_reset();
    mq.delete();
    m_pc    = RESET_PC;
    m_phase = P_BOOT;
    m_shown = 64'h0;
  endfunction

  // One clock of the specified behaviour, using the inputs that were applied at that edge
  function automatic void model_step();
    logic        popped;
    logic        room;
    logic [31:0] w;
    popped = (mq.size() != 0) && out_ready;
    room   = (mq.size() < QDEPTH) || popped;
    if (redirect_valid) begin
      mq.delete();
      m_pc    = {redirect_pc[31:2], 2'b00};
      m_phase = P_RUN;
    end else begin
      if (popped) void'(mq.pop_front());
      if (m_phase == P_BOOT) begin
        m_phase = P_RUN;
      end else if (m_phase == P_RUN && room) begin
        w = mem[m_pc[7:2]];
        if (w == 32'h0) begin
          m_phase = P_HALT;
        end else begin
          mq.push_back({m_pc, w});
          m_pc = m_pc + 32'd4;
        end
      end
    end
    if (mq.size() != 0) m_shown = mq[0];
  endfunction

  initial model_reset();

  // Inputs only change at negedge+2, so at negedge they still hold the values of the last posedge
  always @(negedge clk) begin
    if (!rst_n) model_reset();
    else        model_step();
    check("valid",  32'(out_valid), 32'(mq.size() != 0));
    check("pc",     out_pc,         m_shown[63:32]);
    check("instr",  out_instr,      m_shown[31:0]);
    check("addr",   imem_addr,      m_pc);
    check("halted", 32'(halted),    32'(m_phase == P_HALT));
  end

  task automatic redirect_to(input logic [31:0] target);
    #2;
    redirect_valid = 1'b1;
    redirect_pc    = target;
    @(negedge clk);
  endtask

  initial begin
    logic found;
    for (int i = 0; i < 64; i++) mem[i] = 32'h0;
    mem[0] = 32'h0198_06B3;
    mem[1] = 32'h4034_02B3;
    mem[2] = 32'h0031_70B3;
    rst_n          = 1'b0;
    out_ready      = 1'b1;
    redirect_valid = 1'b0;
    redirect_pc    = 32'h0;

    // straight-line fetch
    repeat (2) @(negedge clk);
    check("rst_valid", 32'(out_valid), 32'h0);
    check("rst_pc", out_pc, 32'h0);
    #2 rst_n = 1'b1;
    @(negedge clk);
    check("boot_valid", 32'(out_valid), 32'h0);
    @(negedge clk);
    check("c2_pc", out_pc, 32'h0);
    check("c2_instr", out_instr, 32'h0198_06B3);
    @(negedge clk);
    check("c3_pc", out_pc, 32'h4);
    check("c3_instr", out_instr, 32'h4034_02B3);
    @(negedge clk);
    check("c4_pc", out_pc, 32'h8);
    check("c4_instr", out_instr, 32'h0031_70B3);
    check("c4_halted", 32'(halted), 32'h0);
    @(negedge clk);
    check("c5_halted", 32'(halted), 32'h1);
    check("c5_addr", imem_addr, 32'hC);
    @(negedge clk);
    check("c6_addr", imem_addr, 32'hC);

    // redirect out of HALT
    redirect_to(32'h0);
    check("rh_halted", 32'(halted), 32'h0);
    check("rh_bubble", 32'(out_valid), 32'h0);
    #2 redirect_valid = 1'b0;
    @(negedge clk);
    check("rh_valid", 32'(out_valid), 32'h1);
    check("rh_instr", out_instr, 32'h0198_06B3);
    repeat (5) @(negedge clk);

    // backpressure
    #2 out_ready = 1'b0;
    redirect_to(32'h0);
    #2 redirect_valid = 1'b0;
    repeat (5) @(negedge clk);
    check("bp_addr", imem_addr, 32'h8);
    check("bp_pc", out_pc, 32'h0);
    check("bp_valid", 32'(out_valid), 32'h1);
    #2 out_ready = 1'b1;
    @(negedge clk);
    check("bp_second", out_pc, 32'h4);
    @(negedge clk);
    check("bp_third", out_pc, 32'h8);
    @(negedge clk);
    check("bp_drained", 32'(out_valid), 32'h0);
    check("bp_halted", 32'(halted), 32'h1);

    // redirect mid-stream while head is 0x4
    redirect_to(32'h0);
    #2 redirect_valid = 1'b0;
    found = 1'b0;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      if (out_valid && out_pc == 32'h4) begin
        found = 1'b1;
        break;
      end
    end
    check("ms_head_seen", 32'(found), 32'h1);
    redirect_to(32'h5);
    check("ms_bubble", 32'(out_valid), 32'h0);
    #2 redirect_valid = 1'b0;
    @(negedge clk);
    check("ms_valid", 32'(out_valid), 32'h1);
    check("ms_pc", out_pc, 32'h4);
    check("ms_instr", out_instr, 32'h4034_02B3);

    // async reset mid-period with a full queue
    #2 out_ready = 1'b0;
    redirect_to(32'h0);
    #2 redirect_valid = 1'b0;
    repeat (3) @(negedge clk);
    check("ar_pre_addr", imem_addr, 32'h8);
    @(posedge clk);
    #3 rst_n = 1'b0;
    #1;
    check("ar_valid", 32'(out_valid), 32'h0);
    check("ar_addr", imem_addr, RESET_PC);
    out_ready = 1'b1;
    @(negedge clk);
    #2 rst_n = 1'b1;
    @(negedge clk);
    check("ar_boot", 32'(out_valid), 32'h0);
    @(negedge clk);
    check("ar_restart_valid", 32'(out_valid), 32'h1);
    check("ar_restart_pc", out_pc, RESET_PC);

    // randomized traffic
    #2;
    for (int i = 0; i < 64; i++) mem[i] = ($urandom_range(0, 7) == 0) ? 32'h0 : $urandom();
    redirect_valid = 1'b1;
    redirect_pc    = 32'h0;
    for (int cyc = 0; cyc < 800; cyc++) begin
      @(negedge clk);
      #2;
      out_ready      = ($urandom_range(0, 9) < 7);
      redirect_valid = halted ? ($urandom_range(0, 2) == 0) : ($urandom_range(0, 11) == 0);
      redirect_pc    = ($urandom_range(0, 3) == 0) ? $urandom() : 32'($urandom_range(0, 255));
    end
    redirect_valid = 1'b0;
    repeat (4) @(negedge clk);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
